// File: rtl/tone_sequence_player.sv
// Square-wave note sequencer that feeds the Audio_Controller DAC-side write interface.
// Define TONE_LOOP_EN to loop the sequence forever instead of stopping in DONE.
module tone_sequence_player #(
  parameter int unsigned NUM_NOTES  = 17,
  parameter logic [31:0] AMPLITUDE  = 32'd100000000,
  parameter logic [31:0] GAP_CYCLES = 32'd0
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        restart,
  output logic [7:0]  note_addr,
  input  logic [31:0] note_half_period,
  input  logic [31:0] note_duration,
  input  logic        audio_out_allowed,
  output logic        write_audio_out,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out,
  output logic        playing,
  output logic        done
);

  localparam logic [7:0]  LastAddr = 8'(NUM_NOTES - 1);
  localparam logic [31:0] AmpNeg   = ~AMPLITUDE + 32'd1;

  typedef enum logic [2:0] {StIdle, StLoad, StPlay, StGap, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] hp_q, hp_d;
  logic [31:0] dur_q, dur_d;
  logic [31:0] dur_cnt_q, dur_cnt_d;
  logic [31:0] per_cnt_q, per_cnt_d;
  logic [31:0] gap_cnt_q, gap_cnt_d;
  logic        sign_q, sign_d;
  logic [31:0] sample_q, sample_d;
  logic        advance;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    hp_d      = hp_q;
    dur_d     = dur_q;
    dur_cnt_d = dur_cnt_q;
    per_cnt_d = per_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sign_d    = sign_q;
    advance   = 1'b0;

    if (!enable) begin
      state_d   = StIdle;
      addr_d    = 8'd0;
      dur_cnt_d = 32'd0;
      per_cnt_d = 32'd0;
      gap_cnt_d = 32'd0;
      sign_d    = 1'b0;
    end else if (restart) begin
      state_d = StLoad;
      addr_d  = 8'd0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StLoad;
        StLoad: begin
          hp_d      = note_half_period;
          dur_d     = (note_duration == 32'd0) ? 32'd1 : note_duration;
          dur_cnt_d = 32'd0;
          per_cnt_d = 32'd0;
          gap_cnt_d = 32'd0;
          sign_d    = 1'b0;
          state_d   = StPlay;
        end
        StPlay: begin
          dur_cnt_d = dur_cnt_q + 32'd1;
          if (hp_q != 32'd0) begin
            if (per_cnt_q == hp_q - 32'd1) begin
              per_cnt_d = 32'd0;
              sign_d    = ~sign_q;
            end else begin
              per_cnt_d = per_cnt_q + 32'd1;
            end
          end
          if (dur_cnt_q == dur_q - 32'd1) begin
            if (GAP_CYCLES != 32'd0) begin
              state_d   = StGap;
              gap_cnt_d = 32'd0;
            end else begin
              advance = 1'b1;
            end
          end
        end
        StGap: begin
          gap_cnt_d = gap_cnt_q + 32'd1;
          if (gap_cnt_q == GAP_CYCLES - 32'd1) advance = 1'b1;
        end
        StDone: state_d = StDone;
        default: state_d = StIdle;
      endcase
    end

    if (advance) begin
      if (addr_q == LastAddr) begin
`ifdef TONE_LOOP_EN
        addr_d  = 8'd0;
        state_d = StLoad;
`else
        state_d = StDone;
`endif
      end else begin
        addr_d  = addr_q + 8'd1;
        state_d = StLoad;
      end
    end

    // Sample is derived from next state so it lines up with the PLAY cycle it belongs to.
    if (state_d == StPlay && hp_d != 32'd0) begin
      sample_d = sign_d ? AmpNeg : AMPLITUDE;
    end else begin
      sample_d = 32'd0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      addr_q    <= 8'd0;
      hp_q      <= 32'd0;
      dur_q     <= 32'd0;
      dur_cnt_q <= 32'd0;
      per_cnt_q <= 32'd0;
      gap_cnt_q <= 32'd0;
      sign_q    <= 1'b0;
      sample_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      hp_q      <= hp_d;
      dur_q     <= dur_d;
      dur_cnt_q <= dur_cnt_d;
      per_cnt_q <= per_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sign_q    <= sign_d;
      sample_q  <= sample_d;
    end
  end

  assign note_addr               = addr_q;
  assign playing                 = (state_q == StLoad) || (state_q == StPlay) ||
                                   (state_q == StGap);
  assign done                    = (state_q == StDone);
  assign write_audio_out         = audio_out_allowed & playing;
  assign left_channel_audio_out  = sample_q;
  assign right_channel_audio_out = sample_q;

endmodule
